// File: rtl/pc_sequencer.sv
// Next-PC controller: picks hold / increment / redirect each cycle and keeps one pending redirect.
// Optional perf counters are built only when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  input  logic        ihit,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        PCen,
  output logic [31:0] pc_next,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  // Handshake: pc_next is consumed by the PC register only in cycles where PCen=1;
  // stall is always the complement of PCen.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target;

  assign target = {redirect_target[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    PCen    = 1'b0;
    pc_next = pc;
    flush   = 1'b0;
    halted  = 1'b0;
    if (RST) begin
      pc_next = PC_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALT;
          end else if (redirect_valid) begin
            flush = 1'b1;
            if (ihit) begin
              PCen    = 1'b1;
              pc_next = target;
            end else begin
              pend_d  = target;
              state_d = PEND;
            end
          end else if (ihit && !hazard_stall) begin
            PCen    = 1'b1;
            pc_next = pc + PC_INC;
          end
        end
        PEND: begin
          // Hazard stalls do not matter here: the fetch is already being thrown away.
          if (halt) begin
            state_d = HALT;
          end else if (redirect_valid) begin
            pend_d = target;
            flush  = 1'b1;
            if (ihit) begin
              PCen    = 1'b1;
              pc_next = target;
              state_d = RUN;
            end
          end else if (ihit) begin
            PCen    = 1'b1;
            pc_next = pend_q;
            state_d = RUN;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign stall = ~PCen;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= 32'h0;
      redir_cnt_q <= 32'h0;
    end else begin
      if (stall && (state_q != HALT) && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect_valid && !halt && (state_q != HALT) && (redir_cnt_q != 32'hFFFF_FFFF))
        redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign redirect_count = redir_cnt_q;
`else
  assign stall_cycles   = 32'h0;
  assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table plus a short random RUN segment,
// expected outputs pushed to a queue at drive time and popped at the sample point.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ihit;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        stall;
  logic        flush;
  logic        halted;
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;

  int n_cmp = 0;
  int n_err = 0;

  // {PCen, stall, flush, halted, pc_next}
  logic [35:0] exp_q[$];

  pc_sequencer dut (
    .CLK            (clk),
    .RST            (rst),
    .pc             (pc),
    .ihit           (ihit),
    .hazard_stall   (hazard_stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .PCen           (pc_en),
    .pc_next        (pc_next),
    .stall          (stall),
    .flush          (flush),
    .halted         (halted),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
  task automatic cyc(input string tag, input logic r, input logic [31:0] p, input logic ih,
                     input logic hz, input logic rv, input logic [31:0] tgt, input logic hl,
                     input logic e_en, input logic e_flush, input logic e_halted,
                     input logic [31:0] e_next);
    logic [35:0] e;
    rst = r; pc = p; ihit = ih; hazard_stall = hz;
    redirect_valid = rv; redirect_target = tgt; halt = hl;
    exp_q.push_back({e_en, ~e_en, e_flush, e_halted, e_next});
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {pc_en, stall, flush, halted, pc_next}, e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input logic [31:0] s, input logic [31:0] r);
`ifdef PC_SEQ_PERF_EN
    check({tag, "_stall"}, {4'h0, stall_cycles}, {4'h0, s});
    check({tag, "_redir"}, {4'h0, redirect_count}, {4'h0, r});
`else
    check({tag, "_stall"}, {4'h0, stall_cycles}, 36'h0);
    check({tag, "_redir"}, {4'h0, redirect_count}, 36'h0);
`endif
  endtask

  initial begin
    logic [31:0] p;
    logic        h, ih;
    // reset: pc_next must be PC_RESET, not pc
    cyc("rst0", 1, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc("rst1", 1, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_perf("perf_rst", 0, 0);
    cyc("seq0", 0, 32'h0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h4);

    // hazard stall holds pc
    for (int i = 0; i < 3; i++)
      cyc("hz", 0, 32'h100, 1, 1, 0, 0, 0, 0, 0, 0, 32'h100);
    cyc("hz_rel", 0, 32'h100, 1, 0, 0, 0, 0, 1, 0, 0, 32'h104);

    // redirect during outstanding fetch -> PEND, aligned target
    cyc("pend_in", 0, 32'h200, 0, 0, 1, 32'h403, 0, 0, 1, 0, 32'h200);
    cyc("pend_w0", 0, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0, 32'h200);
    cyc("pend_w1", 0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200);
    cyc("pend_out", 0, 32'h200, 1, 1, 0, 0, 0, 1, 0, 0, 32'h400);
    cyc("run_chk0", 0, 32'h400, 1, 0, 0, 0, 0, 1, 0, 0, 32'h404);

    // new redirect with ihit while pending
    cyc("pend_in2", 0, 32'h300, 0, 0, 1, 32'h401, 0, 0, 1, 0, 32'h300);
    cyc("pend_new", 0, 32'h300, 1, 0, 1, 32'h802, 0, 1, 1, 0, 32'h800);
    cyc("run_chk1", 0, 32'h900, 1, 0, 0, 0, 0, 1, 0, 0, 32'h904);

    // newest of several pending redirects wins
    cyc("pend_a", 0, 32'h500, 0, 0, 1, 32'hA00, 0, 0, 1, 0, 32'h500);
    cyc("pend_b", 0, 32'h500, 0, 0, 1, 32'hB01, 0, 0, 1, 0, 32'h500);
    cyc("pend_b_out", 0, 32'h500, 1, 0, 0, 0, 0, 1, 0, 0, 32'hB00);

    // random RUN segment
    for (int i = 0; i < 12; i++) begin
      p  = $urandom & 32'hFFFF_FFFC;
      h  = 1'($urandom_range(0, 1));
      ih = 1'($urandom_range(0, 1));
      cyc("rnd", 0, p, ih, h, 0, 0, 0, ih & ~h, 0, 0, (ih & ~h) ? p + 32'd4 : p);
    end

    // wrap, redirect with hit, then halt beats redirect
    cyc("wrap", 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    cyc("redir_hit", 0, 32'h40, 1, 0, 1, 32'h1237, 0, 1, 1, 0, 32'h1234);
    cyc("halt_in", 0, 32'h50, 1, 0, 1, 32'h700, 1, 0, 0, 0, 32'h50);
    for (int i = 0; i < 4; i++) begin
      p = $urandom & 32'hFFFF_FFFC;
      cyc("halt_sticky", 0, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 32'h900, 1'($urandom_range(0, 1)), 0, 0, 1, p);
    end
    cyc("rst_halt", 1, 32'h60, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc("post_halt", 0, 32'h10, 1, 0, 0, 0, 0, 1, 0, 0, 32'h14);

    // halt while pending drops the redirect
    cyc("pend_in3", 0, 32'h30, 0, 0, 1, 32'hC00, 0, 0, 1, 0, 32'h30);
    cyc("pend_halt", 0, 32'h30, 1, 0, 0, 0, 1, 0, 0, 0, 32'h30);
    cyc("pend_halted", 0, 32'h30, 1, 0, 0, 0, 0, 0, 0, 1, 32'h30);

    // perf counters: 5 stalls, 2 redirects accepted with hit (no extra stalls)
    cyc("rst_perf", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_perf("perf_clr", 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("perf_hz", 0, 32'h80, 1, 1, 0, 0, 0, 0, 0, 0, 32'h80);
    cyc("perf_r0", 0, 32'h80, 1, 0, 1, 32'h100, 0, 1, 1, 0, 32'h100);
    cyc("perf_r1", 0, 32'h100, 1, 0, 1, 32'h200, 0, 1, 1, 0, 32'h200);
    check_perf("perf_cnt", 5, 2);
    cyc("rst_perf2", 1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_perf("perf_clr2", 0, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
